stream_arbiter: RTL and testbench
=================================

STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data width of every stream.
REQ-002 The block SHALL have parameter CHANNELS, default 4, range 2..16, meaning the number of input streams.
REQ-003 The block SHALL have parameter EXC_STICKY, default 1; when 1, exception holds until reset; when 0, exception follows the registered OR.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port input_in, input, CHANNELS*WIDTH bits: channel k data occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port input_in_stb, input, CHANNELS bits: per-channel data valid.
REQ-008 The block SHALL have port input_in_ack, output, CHANNELS bits: per-channel accept, registered.
REQ-009 The block SHALL have port output_out, output, WIDTH bits: the merged data, registered.
REQ-010 The block SHALL have port output_out_chan, output, $clog2(CHANNELS) bits: the source channel of output_out.
REQ-011 The block SHALL have port output_out_stb, output, 1 bit: output valid, registered.
REQ-012 The block SHALL have port output_out_ack, input, 1 bit: downstream accept.
REQ-013 The block SHALL have port exception_in, input, CHANNELS bits: per-process exception flags.
REQ-014 The block SHALL have port exception, output, 1 bit: the aggregated exception, registered.

Function
REQ-015 A transfer SHALL occur on an edge where stb and ack are both high; a producer holds data and stb stable until that edge.
REQ-016 The FSM SHALL have states IDLE, ACCEPT and SEND.
REQ-017 In IDLE with any input_in_stb bit high, the FSM SHALL select grant g (REQ-018), assert input_in_ack[g] only, and go to ACCEPT.
REQ-018 The grant SHALL be the first channel with stb high, searching upward from last_grant+1 modulo CHANNELS (round-robin).
REQ-019 In ACCEPT with input_in_stb[g] high, the block SHALL capture the channel data into output_out, set output_out_chan=g, drop input_in_ack, raise output_out_stb and go to SEND.
REQ-020 In ACCEPT with input_in_stb[g] low, the block SHALL drop input_in_ack, transfer nothing, leave last_grant unchanged and return to IDLE.
REQ-021 In SEND, output_out, output_out_chan and output_out_stb SHALL hold until output_out_ack is sampled high.
REQ-022 When output_out_ack is sampled high in SEND, the block SHALL clear output_out_stb, set last_grant=g and return to IDLE.
REQ-023 At most one input_in_ack bit SHALL ever be high, for exactly one cycle per grant.
REQ-024 The minimum latency from input stb to output stb SHALL be 2 cycles; the maximum throughput SHALL be one word per 3 cycles.
REQ-025 Stb changes on non-granted channels SHALL NOT disturb an ongoing ACCEPT or SEND.
REQ-026 The exception output SHALL be the OR of exception_in, registered one cycle; with EXC_STICKY=1 it SHALL be set-only.

Reset
REQ-027 On reset assertion, the state SHALL go to IDLE asynchronously, with input_in_ack=0, output_out_stb=0, output_out=0, output_out_chan=0, exception=0 and last_grant=CHANNELS-1.
REQ-028 A reset during ACCEPT or SEND SHALL discard the word in flight; no stb or ack SHALL be asserted in the first cycle after reset release.

Configuration
REQ-029 With macro STREAM_ARBITER_FIXED_PRIORITY_EN defined, the grant SHALL be the lowest-indexed channel with stb high, and last_grant SHALL be ignored.
REQ-030 Without STREAM_ARBITER_FIXED_PRIORITY_EN, the grant SHALL follow the round-robin rule of REQ-018.

Verification
REQ-031 Reset test: set CHANNELS=4 and drive input_in_stb=4'b0001 with ch0 data 0x11 -> input_in_ack=4'b0001 one cycle later, output_out_stb high 2 cycles after stb with output_out=0x11 and output_out_chan=0.
REQ-032 Round-robin test: hold stb on all 4 channels with data 0xA0..0xA3 and output_out_ack tied high -> output order is channels 0,1,2,3,0 at one word per 3 cycles.
REQ-033 Backpressure test: hold output_out_ack low for 10 cycles in SEND -> output_out_stb and data stay constant, and no input_in_ack is asserted during that time.
REQ-034 Stb drop test: deassert ch2 stb in the ACCEPT cycle -> no output, FSM returns to IDLE, and ch2 is granted again next if it is still the only requester.
REQ-035 Exception and reset test: pulse exception_in[3] for 1 cycle -> exception goes high 1 cycle later and stays high (EXC_STICKY=1); assert rst mid-SEND -> all outputs are 0 immediately.
REQ-036 Fixed-priority test: define STREAM_ARBITER_FIXED_PRIORITY_EN and hold all stb high -> channel 0 is granted on every grant.

Source files
------------

// File: rtl/stream_arbiter.sv
// Round-robin N:1 stream arbiter with an IDLE/ACCEPT/SEND handshake FSM and an aggregated exception flag.
// Define STREAM_ARBITER_FIXED_PRIORITY_EN to grant the lowest-indexed requester instead of round-robin.
module stream_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned EXC_STICKY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*WIDTH-1:0]   input_in,
  input  logic [CHANNELS-1:0]         input_in_stb,
  output logic [CHANNELS-1:0]         input_in_ack,
  output logic [WIDTH-1:0]            output_out,
  output logic [$clog2(CHANNELS)-1:0] output_out_chan,
  output logic                        output_out_stb,
  input  logic                        output_out_ack,
  input  logic [CHANNELS-1:0]         exception_in,
  output logic                        exception
);

  localparam int unsigned CW = $clog2(CHANNELS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       grant_q, grant_d;
  logic [CW-1:0]       last_q, last_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [CHANNELS-1:0] ack_q, ack_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                ostb_q, ostb_d;
  logic                exc_q, exc_d;
  logic [CW-1:0]       pick_c;
  logic [WIDTH-1:0]    sel_data_c;

`ifdef STREAM_ARBITER_FIXED_PRIORITY_EN
  // Lowest-indexed requester wins; scanning downward leaves the smallest index.
  always_comb begin
    pick_c = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (input_in_stb[i]) pick_c = CW'(i);
    end
  end
`else
  logic [CW-1:0] idx_c;

  // Round-robin: nearest requester above last_grant wins, so scan from the farthest offset down.
  always_comb begin
    pick_c = '0;
    idx_c  = '0;
    for (int i = int'(CHANNELS); i >= 1; i--) begin
      idx_c = CW'((int'(last_q) + i) % int'(CHANNELS));
      if (input_in_stb[idx_c]) pick_c = idx_c;
    end
  end
`endif

  // Data of the currently granted channel.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (grant_q == CW'(k)) sel_data_c = input_in[k*WIDTH +: WIDTH];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    chan_d  = chan_q;
    data_d  = data_q;
    ostb_d  = ostb_q;
    ack_d   = '0;
    exc_d   = (EXC_STICKY != 0) ? (exc_q | (|exception_in)) : (|exception_in);
    case (state_q)
      ST_IDLE: begin
        if (|input_in_stb) begin
          grant_d        = pick_c;
          ack_d[pick_c]  = 1'b1;
          state_d        = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (input_in_stb[grant_q]) begin
          data_d  = sel_data_c;
          chan_d  = grant_q;
          ostb_d  = 1'b1;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (output_out_ack) begin
          ostb_d  = 1'b0;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= CW'(CHANNELS - 1);
      chan_q  <= '0;
      data_q  <= '0;
      ostb_q  <= 1'b0;
      ack_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      chan_q  <= chan_d;
      data_q  <= data_d;
      ostb_q  <= ostb_d;
      ack_q   <= ack_d;
      exc_q   <= exc_d;
    end
  end

  assign input_in_ack    = ack_q;
  assign output_out      = data_q;
  assign output_out_chan = chan_q;
  assign output_out_stb  = ostb_q;
  assign exception       = exc_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter: directed scenarios plus randomized traffic checked by a negedge monitor.
module tb_stream_arbiter;

  localparam int unsigned W       = 32;
  localparam int unsigned N       = 4;
  localparam int unsigned CW      = 2;
  localparam int          TIMEOUT = 50;
`ifdef STREAM_ARBITER_FIXED_PRIORITY_EN
  localparam bit FIXED_PRI = 1'b1;
`else
  localparam bit FIXED_PRI = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] input_in;
  logic [N-1:0]   input_in_stb;
  logic [N-1:0]   input_in_ack;
  logic [W-1:0]   output_out;
  logic [CW-1:0]  output_out_chan;
  logic           output_out_stb;
  logic           output_out_ack;
  logic [N-1:0]   exception_in;
  logic           exception;
  logic [W-1:0]   din [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < int'(N); k++) input_in[k*W +: W] = din[k];
  end

  stream_arbiter #(.WIDTH(W), .CHANNELS(N), .EXC_STICKY(1)) dut (
    .clk(clk), .rst(rst),
    .input_in(input_in), .input_in_stb(input_in_stb), .input_in_ack(input_in_ack),
    .output_out(output_out), .output_out_chan(output_out_chan),
    .output_out_stb(output_out_stb), .output_out_ack(output_out_ack),
    .exception_in(exception_in), .exception(exception)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_out = 0;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [CW-1:0] c;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference grant: first requester scanning upward from base+1 modulo N (base=-1 means start at 0).
  function automatic int ref_pick(input int last, input logic [N-1:0] s);
    int base;
    int r;
    base = FIXED_PRI ? -1 : last;
    r = -1;
    for (int k = 1; k <= int'(N); k++) begin
      if (r < 0 && s[(base + k) % int'(N)]) r = (base + k) % int'(N);
    end
    return r;
  endfunction

  // Monitor / scoreboard, sampling at the falling edge.
  int            last_m;
  logic [N-1:0]  prev_stb, prev_exc, req_ack;
  logic          exc_m;
  logic [W-1:0]  held_d;
  logic [CW-1:0] held_c;
  bit            held_v, prev_hs;
  int            g_m;
  exp_t          e, e_in;

  always @(negedge clk) begin
    if (!rst) begin
      last_m   = int'(N) - 1;
      exp_q.delete();
      prev_stb = '0;
      prev_exc = '0;
      exc_m    = 1'b0;
      held_v   = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      exc_m = exc_m | (|prev_exc);
      chk("exception", 64'(exception), 64'(exc_m));
      prev_exc = exception_in;
      if (prev_hs) chk("stb_clear_after_ack", 64'(output_out_stb), 64'(0));
      if (input_in_ack != '0) begin
        g_m     = ref_pick(last_m, prev_stb);
        req_ack = (g_m < 0) ? '0 : (N'(1) << g_m);
        chk("ack_onehot", 64'($onehot(input_in_ack)), 64'(1));
        chk("grant", 64'(input_in_ack), 64'(req_ack));
      end
      if (output_out_stb) chk("ack_while_out_stb", 64'(input_in_ack), 64'(0));
      for (int k = 0; k < int'(N); k++) begin
        if (input_in_ack[k] && input_in_stb[k]) begin
          e_in.d = din[k];
          e_in.c = CW'(k);
          exp_q.push_back(e_in);
        end
      end
      if (output_out_stb) begin
        if (held_v) begin
          chk("hold_data", 64'(output_out), 64'(held_d));
          chk("hold_chan", 64'(output_out_chan), 64'(held_c));
        end
        held_d = output_out;
        held_c = output_out_chan;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      prev_hs = output_out_stb && output_out_ack;
      if (prev_hs) begin
        held_v = 1'b0;
        chk("out_pending", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", 64'(output_out), 64'(e.d));
          chk("out_chan", 64'(output_out_chan), 64'(e.c));
          last_m = int'(e.c);
          n_out++;
        end
      end
      prev_stb = input_in_stb;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int k);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < TIMEOUT; t++) begin
      tick();
      if (input_in_ack[k]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ack_within_bound", 64'(ok), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, required done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] hs;
    int got, tprev;
    rst            = 1'b0;
    input_in_stb   = '0;
    output_out_ack = 1'b0;
    exception_in   = '0;
    for (int k = 0; k < int'(N); k++) din[k] = '0;
    repeat (3) tick();
    chk("rst_ack", 64'(input_in_ack), 64'(0));
    chk("rst_out_stb", 64'(output_out_stb), 64'(0));
    chk("rst_out", 64'(output_out), 64'(0));
    chk("rst_chan", 64'(output_out_chan), 64'(0));
    chk("rst_exc", 64'(exception), 64'(0));
    rst = 1'b1;

    // Single word on ch0: ack one cycle later, output two cycles after stb.
    din[0] = 32'h11;
    input_in_stb = 4'b0001;
    @(negedge clk);
    chk("t1_no_ack_after_release", 64'(input_in_ack), 64'(0));
    tick();
    chk("t1_ack", 64'(input_in_ack), 64'(4'b0001));
    tick();
    input_in_stb = '0;
    chk("t1_out_stb", 64'(output_out_stb), 64'(1));
    chk("t1_out", 64'(output_out), 64'(32'h11));
    chk("t1_chan", 64'(output_out_chan), 64'(0));
    chk("t1_ack_dropped", 64'(input_in_ack), 64'(0));
    output_out_ack = 1'b1;
    tick();
    output_out_ack = 1'b0;
    chk("t1_stb_clear", 64'(output_out_stb), 64'(0));

    // Backpressure on ch1 for 10 cycles while other channels toggle.
    din[1] = 32'hB1;
    input_in_stb = 4'b0010;
    wait_ack(1);
    tick();
    input_in_stb = '0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_stb", 64'(output_out_stb), 64'(1));
      chk("bp_data", 64'(output_out), 64'(32'hB1));
      chk("bp_ack", 64'(input_in_ack), 64'(0));
      input_in_stb = 4'($urandom) & 4'b1101;
      tick();
    end
    input_in_stb   = '0;
    output_out_ack = 1'b1;
    tick();
    output_out_ack = 1'b0;

    // Stb dropped on ch2 during ACCEPT, then ch2 re-granted.
    din[2] = 32'hC2;
    input_in_stb = 4'b0100;
    wait_ack(2);
    input_in_stb = '0;
    tick();
    chk("drop_no_out", 64'(output_out_stb), 64'(0));
    chk("drop_no_ack", 64'(input_in_ack), 64'(0));
    input_in_stb = 4'b0100;
    wait_ack(2);
    chk("drop_regrant", 64'(input_in_ack), 64'(4'b0100));
    tick();
    input_in_stb = '0;
    chk("drop_out", 64'(output_out), 64'(32'hC2));
    chk("drop_chan", 64'(output_out_chan), 64'(2));
    output_out_ack = 1'b1;
    tick();
    output_out_ack = 1'b0;

    // Exception pulse is registered and sticky.
    exception_in = 4'b1000;
    tick();
    exception_in = '0;
    chk("exc_set", 64'(exception), 64'(1));
    repeat (3) tick();
    chk("exc_sticky", 64'(exception), 64'(1));

    // Reset in SEND clears everything at once; nothing asserted in the cycle after release.
    din[1] = 32'hD1;
    input_in_stb = 4'b0010;
    wait_ack(1);
    tick();
    chk("mid_send_stb", 64'(output_out_stb), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("async_rst_stb", 64'(output_out_stb), 64'(0));
    chk("async_rst_out", 64'(output_out), 64'(0));
    chk("async_rst_chan", 64'(output_out_chan), 64'(0));
    chk("async_rst_ack", 64'(input_in_ack), 64'(0));
    chk("async_rst_exc", 64'(exception), 64'(0));
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rel_no_ack", 64'(input_in_ack), 64'(0));
    chk("rel_no_stb", 64'(output_out_stb), 64'(0));
    tick();
    chk("rel_grant", 64'(input_in_ack), 64'(4'b0010));
    tick();
    input_in_stb = '0;
    chk("rel_out", 64'(output_out), 64'(32'hD1));
    output_out_ack = 1'b1;
    tick();
    output_out_ack = 1'b0;

    // All channels requesting, sink always ready: order and rate.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < int'(N); k++) din[k] = 32'hA0 + 32'(k);
    input_in_stb   = 4'hF;
    output_out_ack = 1'b1;
    got   = 0;
    tprev = 0;
    for (int t = 0; t < 60 && got < 5; t++) begin
      @(negedge clk);
      if (output_out_stb) begin
        chk("rr_chan", 64'(output_out_chan), FIXED_PRI ? 64'(0) : 64'(got % 4));
        chk("rr_data", 64'(output_out), FIXED_PRI ? 64'(32'hA0) : 64'(32'hA0 + 32'(got % 4)));
        if (got > 0) chk("rr_gap", 64'(t - tprev), 64'(3));
        tprev = t;
        got++;
      end
    end
    chk("rr_count", 64'(got), 64'(5));
    tick();
    input_in_stb = '0;
    repeat (5) tick();
    output_out_ack = 1'b0;

    // Randomized traffic with backpressure, ACCEPT-cycle drops and exception pulses.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      hs = input_in_ack & input_in_stb;
      tick();
      for (int k = 0; k < int'(N); k++) begin
        if (hs[k]) input_in_stb[k] = 1'b0;
        if (input_in_ack[k] && input_in_stb[k] && $urandom_range(15) == 0) input_in_stb[k] = 1'b0;
        if (!input_in_stb[k] && !input_in_ack[k] && $urandom_range(3) == 0) begin
          input_in_stb[k] = 1'b1;
          din[k] = $urandom;
        end
      end
      output_out_ack = 1'($urandom_range(1));
      exception_in   = ($urandom_range(63) == 0) ? 4'($urandom) : '0;
    end
    input_in_stb   = '0;
    exception_in   = '0;
    output_out_ack = 1'b1;
    repeat (10) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("random_traffic", 64'(n_out > 100), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
